vga_sprite_mixer: RTL and testbench
===================================

Name: vga_sprite_mixer

Overview:
Parametrised N-channel rectangular sprite overlay stage for the VGA pixel pipeline. It sits between draw_background and the output register stage and composites up to N_SPR solid-colour sprites onto rgb_in with fixed priority. Sprite positions are double-buffered and applied at frame boundaries, so there is no tearing. It also reports per-sprite collisions once per frame.

Parameters:
N_SPR, 4, number of sprite channels (1..8)
SPR_W, 32, sprite width in pixels (1..255)
SPR_H, 32, sprite height in pixels (1..255)

Ports:
pclk  in  1  pixel clock
rst_n  in  1  asynchronous, active-low reset
hcount_in  in  11  horizontal pixel count
vcount_in  in  11  vertical line count
hsync_in  in  1  horizontal sync
vsync_in  in  1  vertical sync
hblnk_in  in  1  horizontal blank
vblnk_in  in  1  vertical blank
rgb_in  in  12  background pixel, {r[11:8], g[7:4], b[3:0]}
xpos  in  12*N_SPR  packed sprite X positions (sprite i at [12i+11:12i])
ypos  in  12*N_SPR  packed sprite Y positions
colour  in  12*N_SPR  packed sprite colours
enable  in  N_SPR  per-sprite enable
hcount_out, vcount_out  out  11  timing outputs, delayed 2 cycles
hsync_out, vsync_out, hblnk_out, vblnk_out  out  1  timing outputs, delayed 2 cycles
rgb_out  out  12  composited pixel
collision  out  N_SPR  per-sprite collision flags for the previous frame
frame_tick  out  1  one-cycle pulse when collision updates

Behaviour:
- Reset: rst_n is asynchronous and active-low.
  - While reset is asserted, all outputs are 0.
  - Active position, colour and enable registers clear to 0.
  - Frame edge detector and collision accumulator clear to 0.
- Shadow buffering:
  - xpos, ypos, colour and enable are sampled into the active registers only on the cycle vsync_in rises (detected against a registered copy of vsync_in).
  - Input changes at any other time have no effect on the current frame.
- Stage 1 (registered):
  - Per sprite i, hit[i] = enable_act[i] & (hcount_in >= x_i) & (hcount_in < x_i + SPR_W) & (vcount_in >= y_i) & (vcount_in < y_i + SPR_H).
  - The comparisons use 13-bit unsigned arithmetic, so there is no wrap-around. A sprite at x_i = 4090 produces no hit at hcount 0..5.
  - Register hit[N_SPR-1:0], rgb_in, the timing signals, and blank = hblnk_in | vblnk_in.
- Stage 2 (registered):
  - If blank, rgb_out = 0.
  - Else if any hit, rgb_out = colour of the lowest-index hit sprite (sprite 0 has highest priority).
  - Else rgb_out = delayed rgb_in.
  - Timing outputs are the stage-1 copies, so total latency is exactly 2 pclk for every output.
- Collision:
  - When not blank and popcount(hit) >= 2, OR hit into the accumulator acc.
  - On the vsync_in rising-edge cycle: collision <= acc (including any contribution made on that same cycle), acc <= 0, and frame_tick = 1 on the following cycle.
  - collision holds its value for the whole next frame.
- Simultaneous events:
  - A shadow update and a collision latch on the same edge both take effect.
  - Hits computed on that cycle still use the pre-update active registers.
- A disabled sprite never hits, never composites and never contributes to collisions.
- Reset mid-frame:
  - Outputs drop to 0 immediately.
  - After release, the first vsync_in rise loads the active registers. Until then no sprite is drawn.

Test Plan:
- Reset and passthrough: hold rst_n=0 → all outputs 0. Release with enable=0 and rgb_in=12'h0F0 in the active area → rgb_out=12'h0F0 exactly 2 cycles later, and all timing outputs are delayed by 2.
- Single sprite: sprite 0 at (100,50), colour 12'hF00, enabled, then apply one vsync rise.
  - rgb_out=12'hF00 for hcount 100..131 on lines 50..81.
  - Background at hcount 99 and 132, and on line 82.
- Priority and collision: sprite 0 (12'hF00) at (200,200), sprite 1 (12'h00F) at (220,210).
  - The overlap shows 12'hF00.
  - After the next vsync rise, collision=4'b0011 and frame_tick pulses once.
  - With the sprites separated, the following frame gives collision=0.
- Shadow buffering: change xpos of sprite 0 from 100 to 300 mid-frame → the current frame still draws at 100, and the next frame draws at 300.
- Boundary: sprite at x=4090 → no pixels at hcount 0..5. During blanking inside the sprite box, rgb_out=0 and no collision is accumulated.
- Async reset mid-frame: drop rst_n while sprites are visible → rgb_out=0 immediately, without waiting for a pclk edge. After release, nothing is drawn until a vsync rise.

Source files
------------

// File: rtl/vga_sprite_mixer.sv
// Two-stage sprite compositor: N_SPR solid rectangles over the background, fixed
// priority (sprite 0 on top), positions double-buffered on vsync rise, per-frame collisions.
module vga_sprite_mixer #(
  parameter int unsigned N_SPR = 4,
  parameter int unsigned SPR_W = 32,
  parameter int unsigned SPR_H = 32
) (
  input  logic                 pclk,
  input  logic                 rst_n,
  input  logic [10:0]          hcount_in,
  input  logic [10:0]          vcount_in,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  input  logic                 hblnk_in,
  input  logic                 vblnk_in,
  input  logic [11:0]          rgb_in,
  input  logic [12*N_SPR-1:0]  xpos,
  input  logic [12*N_SPR-1:0]  ypos,
  input  logic [12*N_SPR-1:0]  colour,
  input  logic [N_SPR-1:0]     enable,
  output logic [10:0]          hcount_out,
  output logic [10:0]          vcount_out,
  output logic                 hsync_out,
  output logic                 vsync_out,
  output logic                 hblnk_out,
  output logic                 vblnk_out,
  output logic [11:0]          rgb_out,
  output logic [N_SPR-1:0]     collision,
  output logic                 frame_tick
);

  logic                vs_prev_q, vs_prev_d;
  logic [12*N_SPR-1:0] x_act_q, x_act_d, y_act_q, y_act_d, col_act_q, col_act_d;
  logic [N_SPR-1:0]    en_act_q, en_act_d;

  logic [N_SPR-1:0]    hit_q, hit_d;
  logic [11:0]         rgb1_q, rgb1_d;
  logic [10:0]         hc1_q, hc1_d, vc1_q, vc1_d;
  logic                hs1_q, hs1_d, vs1_q, vs1_d, hb1_q, hb1_d, vb1_q, vb1_d;
  logic                blank1_q, blank1_d;

  logic [10:0]         hc2_q, hc2_d, vc2_q, vc2_d;
  logic                hs2_q, hs2_d, vs2_q, vs2_d, hb2_q, hb2_d, vb2_q, vb2_d;
  logic [11:0]         rgb2_q, rgb2_d;

  logic [N_SPR-1:0]    acc_q, acc_d, coll_q, coll_d;
  logic                tick_q, tick_d;

  logic                vs_rise;
  logic                blank_now;
  logic [3:0]          hit_cnt;
  logic [N_SPR-1:0]    acc_next;
  logic                found;
  logic [11:0]         pix;

  always_comb begin
    vs_rise   = vsync_in & ~vs_prev_q;
    blank_now = hblnk_in | vblnk_in;
    vs_prev_d = vsync_in;

    // Zero-extended to 13 bits so x + SPR_W cannot wrap back into the visible range.
    hit_d   = '0;
    hit_cnt = '0;
    for (int unsigned i = 0; i < N_SPR; i++) begin
      hit_d[i] = en_act_q[i]
        & ({2'b00, hcount_in} >= {1'b0, x_act_q[12*i +: 12]})
        & ({2'b00, hcount_in} <  ({1'b0, x_act_q[12*i +: 12]} + 13'(SPR_W)))
        & ({2'b00, vcount_in} >= {1'b0, y_act_q[12*i +: 12]})
        & ({2'b00, vcount_in} <  ({1'b0, y_act_q[12*i +: 12]} + 13'(SPR_H)));
      hit_cnt = hit_cnt + 4'(hit_d[i]);
    end

    rgb1_d   = rgb_in;
    hc1_d    = hcount_in;
    vc1_d    = vcount_in;
    hs1_d    = hsync_in;
    vs1_d    = vsync_in;
    hb1_d    = hblnk_in;
    vb1_d    = vblnk_in;
    blank1_d = blank_now;

    found = 1'b0;
    pix   = rgb1_q;
    for (int unsigned i = 0; i < N_SPR; i++) begin
      if (hit_q[i] && !found) begin
        pix   = col_act_q[12*i +: 12];
        found = 1'b1;
      end
    end
    rgb2_d = blank1_q ? '0 : pix;
    hc2_d  = hc1_q;
    vc2_d  = vc1_q;
    hs2_d  = hs1_q;
    vs2_d  = vs1_q;
    hb2_d  = hb1_q;
    vb2_d  = vb1_q;

    acc_next = acc_q | ((!blank_now && hit_cnt >= 4'd2) ? hit_d : '0);
    acc_d    = acc_next;
    coll_d   = coll_q;
    tick_d   = vs_rise;

    x_act_d   = x_act_q;
    y_act_d   = y_act_q;
    col_act_d = col_act_q;
    en_act_d  = en_act_q;
    if (vs_rise) begin
      coll_d    = acc_next;
      acc_d     = '0;
      x_act_d   = xpos;
      y_act_d   = ypos;
      col_act_d = colour;
      en_act_d  = enable;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_q <= 1'b0;
      x_act_q   <= '0;
      y_act_q   <= '0;
      col_act_q <= '0;
      en_act_q  <= '0;
      hit_q     <= '0;
      rgb1_q    <= '0;
      hc1_q     <= '0;
      vc1_q     <= '0;
      hs1_q     <= 1'b0;
      vs1_q     <= 1'b0;
      hb1_q     <= 1'b0;
      vb1_q     <= 1'b0;
      blank1_q  <= 1'b0;
      hc2_q     <= '0;
      vc2_q     <= '0;
      hs2_q     <= 1'b0;
      vs2_q     <= 1'b0;
      hb2_q     <= 1'b0;
      vb2_q     <= 1'b0;
      rgb2_q    <= '0;
      acc_q     <= '0;
      coll_q    <= '0;
      tick_q    <= 1'b0;
    end else begin
      vs_prev_q <= vs_prev_d;
      x_act_q   <= x_act_d;
      y_act_q   <= y_act_d;
      col_act_q <= col_act_d;
      en_act_q  <= en_act_d;
      hit_q     <= hit_d;
      rgb1_q    <= rgb1_d;
      hc1_q     <= hc1_d;
      vc1_q     <= vc1_d;
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
      hb1_q     <= hb1_d;
      vb1_q     <= vb1_d;
      blank1_q  <= blank1_d;
      hc2_q     <= hc2_d;
      vc2_q     <= vc2_d;
      hs2_q     <= hs2_d;
      vs2_q     <= vs2_d;
      hb2_q     <= hb2_d;
      vb2_q     <= vb2_d;
      rgb2_q    <= rgb2_d;
      acc_q     <= acc_d;
      coll_q    <= coll_d;
      tick_q    <= tick_d;
    end
  end

  assign hcount_out = hc2_q;
  assign vcount_out = vc2_q;
  assign hsync_out  = hs2_q;
  assign vsync_out  = vs2_q;
  assign hblnk_out  = hb2_q;
  assign vblnk_out  = vb2_q;
  assign rgb_out    = rgb2_q;
  assign collision  = coll_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_vga_sprite_mixer.sv
// Scoreboard bench for vga_sprite_mixer: a rectangle-geometry reference model queues
// expected pixels/collisions; a monitor pops and compares every cycle.
module tb_vga_sprite_mixer;
  localparam int N = 4;
  localparam int W = 32;
  localparam int H = 32;

  logic            pclk = 1'b0;
  logic            rst_n = 1'b0;
  logic [10:0]     hcount_in = '0, vcount_in = '0;
  logic            hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0]     rgb_in = '0;
  logic [12*N-1:0] xpos = '0, ypos = '0, colour = '0;
  logic [N-1:0]    enable = '0;
  logic [10:0]     hcount_out, vcount_out;
  logic            hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0]     rgb_out;
  logic [N-1:0]    collision;
  logic            frame_tick;

  vga_sprite_mixer #(.N_SPR(N), .SPR_W(W), .SPR_H(H)) dut (
    .pclk(pclk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .colour(colour), .enable(enable),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .collision(collision), .frame_tick(frame_tick)
  );

  always #5 pclk = ~pclk;

  typedef struct { logic [11:0] rgb; logic [25:0] tim; } pix_t;
  typedef struct { logic [N-1:0] coll; logic tick; } col_t;

  pix_t pix_q[$];
  col_t coll_q[$];
  int   total = 0;
  int   bad = 0;
  bit   run = 1'b0;
  int   rgb_fix = -1;

  int          m_x[N], m_y[N], m_c[N];
  bit          m_en[N];
  logic [N-1:0] m_acc, m_coll;
  bit          m_vsp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string name);
    check({name, "_rgb"}, 32'(rgb_out), 32'd0);
    check({name, "_tim"}, 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'd0);
    check({name, "_coll"}, 32'({collision, frame_tick}), 32'd0);
  endtask

  // Model state mirrors what the reset clears; the seed entry is the zeroed stage-1 contents.
  task automatic model_clear();
    pix_t z;
    for (int i = 0; i < N; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_c[i] = 0; m_en[i] = 1'b0;
    end
    m_acc = '0; m_coll = '0; m_vsp = 1'b0;
    pix_q.delete();
    coll_q.delete();
    z.rgb = '0; z.tim = '0;
    pix_q.push_back(z);
  endtask

  always @(posedge pclk) begin
    if (run && rst_n) begin
      automatic logic [N-1:0] hm = '0;
      automatic int first = -1;
      automatic int nh = 0;
      automatic bit blank = hblnk_in || vblnk_in;
      automatic bit rise = vsync_in && !m_vsp;
      automatic int hc = int'(hcount_in);
      automatic int vc = int'(vcount_in);
      pix_t e;
      col_t c;
      for (int i = 0; i < N; i++) begin
        if (m_en[i] && hc >= m_x[i] && hc < m_x[i] + W && vc >= m_y[i] && vc < m_y[i] + H) begin
          hm[i] = 1'b1;
          nh++;
          if (first < 0) first = i;
        end
      end
      e.rgb = blank ? 12'h000 : (first >= 0 ? 12'(m_c[first]) : rgb_in);
      e.tim = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
      pix_q.push_back(e);
      if (!blank && nh >= 2) m_acc = m_acc | hm;
      if (rise) begin
        m_coll = m_acc;
        m_acc = '0;
        for (int i = 0; i < N; i++) begin
          m_x[i] = int'(xpos[12*i +: 12]);
          m_y[i] = int'(ypos[12*i +: 12]);
          m_c[i] = int'(colour[12*i +: 12]);
          m_en[i] = enable[i];
        end
      end
      m_vsp = vsync_in;
      c.coll = m_coll;
      c.tick = rise;
      coll_q.push_back(c);
    end
  end

  pix_t pe;
  col_t ce;
  always @(posedge pclk) begin
    #1;
    if (run) begin
      if (pix_q.size() == 0 || coll_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty got=empty want=entry t=%0t", $time);
      end else begin
        pe = pix_q.pop_front();
        ce = coll_q.pop_front();
        check("rgb", 32'(rgb_out), 32'(pe.rgb));
        check("timing", 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'(pe.tim));
        check("collision", 32'(collision), 32'(ce.coll));
        check("frame_tick", 32'(frame_tick), 32'(ce.tick));
      end
    end
  end

  task automatic drive(input int h, input int v, input bit hb, input bit vb, input bit hs, input bit vs);
    @(negedge pclk);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hblnk_in  = hb;
    vblnk_in  = vb;
    hsync_in  = hs;
    vsync_in  = vs;
    rgb_in    = (rgb_fix >= 0) ? 12'(rgb_fix) : 12'($urandom);
  endtask

  task automatic scan(input int v0, input int v1, input int h0, input int h1, input bit fb);
    for (int v = v0; v <= v1; v++) begin
      for (int h = h0; h <= h1; h++) drive(h, v, fb, 1'b0, 1'b0, 1'b0);
      drive(h1 + 1, v, 1'b1, 1'b0, 1'b1, 1'b0);
      drive(h1 + 2, v, 1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic vframe();
    for (int k = 0; k < 9; k++) drive(0, 600 + k, 1'b1, 1'b1, 1'b0, (k >= 3 && k < 6));
  endtask

  task automatic set_spr(input int i, input int x, input int y, input int c, input bit en);
    xpos[12*i +: 12]   = 12'(x);
    ypos[12*i +: 12]   = 12'(y);
    colour[12*i +: 12] = 12'(c);
    enable[i]          = en;
  endtask

  task automatic clr_all();
    for (int i = 0; i < N; i++) set_spr(i, 0, 0, 0, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    run = 1'b0;
    rst_n = 1'b0;
    repeat (3) drive(5, 5, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_zero("reset");
    drive(5, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    model_clear();
    @(negedge pclk);
    rst_n = 1'b1;
    run = 1'b1;

    // passthrough with fixed green background
    rgb_fix = 12'h0F0;
    scan(10, 12, 0, 20, 1'b0);
    rgb_fix = -1;
    scan(13, 14, 0, 20, 1'b0);

    // single sprite
    clr_all();
    set_spr(0, 100, 50, 12'hF00, 1'b1);
    vframe();
    scan(48, 84, 97, 134, 1'b0);

    // priority and collision, then separated sprites
    clr_all();
    set_spr(0, 200, 200, 12'hF00, 1'b1);
    set_spr(1, 220, 210, 12'h00F, 1'b1);
    vframe();
    scan(198, 245, 198, 255, 1'b0);
    set_spr(1, 400, 400, 12'h00F, 1'b1);
    vframe();
    scan(198, 245, 198, 255, 1'b0);
    vframe();
    scan(0, 1, 0, 5, 1'b0);

    // shadow buffering: mid-frame move is deferred
    clr_all();
    set_spr(0, 100, 50, 12'hF00, 1'b1);
    vframe();
    scan(50, 52, 95, 335, 1'b0);
    set_spr(0, 300, 50, 12'hF00, 1'b1);
    scan(53, 55, 95, 335, 1'b0);
    vframe();
    scan(50, 52, 95, 335, 1'b0);

    // boundary: far-right sprite must not wrap, blanking suppresses pixels and collisions
    clr_all();
    set_spr(0, 4090, 0, 12'hABC, 1'b1);
    vframe();
    scan(0, 3, 0, 10, 1'b0);
    clr_all();
    set_spr(0, 20, 20, 12'h123, 1'b1);
    set_spr(1, 30, 25, 12'h456, 1'b1);
    vframe();
    scan(20, 40, 15, 60, 1'b1);
    vframe();
    scan(0, 0, 0, 3, 1'b0);

    // randomised frames with ignored mid-frame shadow writes
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < N; i++)
        set_spr(i, $urandom_range(0, 60), $urandom_range(0, 40), int'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
      vframe();
      scan(0, 20, 0, 70, 1'b0);
      for (int i = 0; i < N; i++)
        set_spr(i, $urandom_range(0, 60), $urandom_range(0, 40), int'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
      scan(21, 45, 0, 70, 1'b0);
    end
    vframe();
    scan(0, 0, 0, 3, 1'b0);

    // async reset while a sprite is on screen
    clr_all();
    set_spr(0, 100, 50, 12'hF00, 1'b1);
    vframe();
    scan(50, 51, 95, 140, 1'b0);
    drive(110, 52, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(111, 52, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(112, 52, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge pclk);
    #1;
    check("pre_rst_visible", 32'(rgb_out), 32'h0F00);
    #1;
    run = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    repeat (3) drive(110, 52, 1'b0, 1'b0, 1'b0, 1'b0);
    model_clear();
    @(negedge pclk);
    rst_n = 1'b1;
    run = 1'b1;
    scan(50, 55, 95, 140, 1'b0);
    vframe();
    scan(50, 55, 95, 140, 1'b0);

    repeat (3) drive(0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge pclk);
    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
